// File: rtl/serial_flag_alu.sv
// serial_flag_alu: bit-serial add/subtract with a registered flag set
// (result, cout, zero, sign, overflow) offered under a valid/ready handshake.
// A single one-bit full-adder slice is reused for WIDTH clocks per operation.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; outputs hold the last completed flag set
// S_RUN  | one sum bit per clock, LSB first; start is ignored
// S_DONE | flag set valid; waits for flags_ready (start here = back-to-back)

module serial_flag_alu #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_flags_valid,
  input  logic             i_flags_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_zero,
  output logic             o_sign,
  output logic             o_overflow
);

  // Counter only ever spans 0..WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_zacc;
  logic [CW-1:0]    r_cnt;

  logic             r_busy;
  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_zero;
  logic             r_sign;
  logic             r_overflow;

  logic             w_sum;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_res_nxt;

  // One-bit full-adder slice working on the LSBs of the operand shifters.
  assign w_sum       = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry_nxt = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_res_nxt   = {w_sum, r_res[WIDTH-1:1]};
  assign w_last      = (r_cnt == LAST_BIT);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the load/step strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_flags_ready) begin
          if (i_start) begin
            w_load      = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture and serial shifting; subtract is a + ~b + 1, so the
  // inverted B and the carry-in of 1 are set up at capture time.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a     <= i_a;
      r_b     <= i_sub ? ~i_b : i_b;
      r_res   <= '0;
      r_carry <= i_sub;
      r_zacc  <= 1'b1;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= w_res_nxt;
      r_carry <= w_carry_nxt;
      r_zacc  <= r_zacc & ~w_sum;
      if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Output flag set; updated only on the edge that finishes the MSB.
  // At that edge r_carry is the carry into the MSB and w_carry_nxt the
  // carry out, which is all overflow needs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_result   <= '0;
      r_cout     <= 1'b0;
      r_zero     <= 1'b0;
      r_sign     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_step && w_last) begin
      r_result   <= w_res_nxt;
      r_cout     <= w_carry_nxt;
      r_zero     <= r_zacc & ~w_sum;
      r_sign     <= w_sum;
      r_overflow <= r_carry ^ w_carry_nxt;
    end
  end

  // Registered status outputs so busy/valid carry no combinational path.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt == S_RUN);
      r_valid <= (w_state_nxt == S_DONE);
    end
  end

  assign o_busy        = r_busy;
  assign o_flags_valid = r_valid;
  assign o_result      = r_result;
  assign o_cout        = r_cout;
  assign o_zero        = r_zero;
  assign o_sign        = r_sign;
  assign o_overflow    = r_overflow;

endmodule
